// File: rtl/fft_bitrev_out.sv
// Ping-pong reorder buffer turning the bit-reversed FFT output stream into natural bin order.
// Define FFT_BITREV_EN to write at bitrev(iaddr); leave it undefined for an unmodified-address passthrough.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 10
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module fft_bitrev_out #(
  parameter int ADDR_W = `TOTAL_STAGE,
  parameter int DATA_W = `CPLX_WIDTH
) (
  input  logic              iclk,
  input  logic              rst_n,
  input  logic              ien,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              oen,
  input  logic              ordy,
  output logic [ADDR_W-1:0] oaddr,
  output logic [DATA_W-1:0] odata,
  output logic              ovf
);

  localparam int DEPTH = 2 * (1 << ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] a1;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wb;
  logic              rb;
  logic              v1;
  logic              adv;
  logic              load1;
  logic              issue;
  logic              wr_ok;
  logic              wr_last;
  logic              rd_last;
  state_t            state;
  state_t            state_nxt;

`ifdef FFT_BITREV_EN
  always_comb begin
    waddr = '0;
    for (int i = 0; i < ADDR_W; i++) waddr[i] = iaddr[ADDR_W-1-i];
  end
`else
  assign waddr = iaddr;
`endif

  always_comb begin
    wr_ok   = ien && !full[wb];
    wr_last = wr_ok && (iaddr == LAST);
    rd_last = issue && (rcnt == LAST);
  end

  // A bank is released once its last word has left the RAM; the pipeline registers hold the tail,
  // which lets the writer reuse the bank immediately under sustained 1 word/cycle input.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wb] = 1'b1;
    if (rd_last) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = issue ? FILL : IDLE;
      FILL:    state_nxt = STREAM;
      STREAM:  if (ordy) state_nxt = v1 ? STREAM : (issue ? FILL : IDLE);
      default: state_nxt = IDLE;
    endcase
  end

  // STREAM means the output register holds a word; v1 marks a word waiting in the RAM read register.
  always_comb begin
    oen   = (state == STREAM);
    adv   = !oen || ordy;
    load1 = !v1 || adv;
    issue = load1 && full[rb];
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      a1    <= '0;
      rcnt  <= '0;
      rb    <= 1'b0;
      wb    <= 1'b0;
      full  <= 2'b00;
      ovf   <= 1'b0;
      oaddr <= '0;
      odata <= '0;
    end else begin
      if (load1) v1 <= issue;
      if (issue) begin
        a1   <= rcnt;
        rcnt <= rcnt + 1'b1;
        if (rcnt == LAST) rb <= ~rb;
      end
      if (wr_last) wb <= ~wb;
      full <= full_nxt;
      if (ien && full[wb] && (iaddr == LAST)) ovf <= 1'b1;
      if (adv && v1) begin
        oaddr <= a1;
        odata <= ram_q;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_ok) mem[{wb, waddr}] <= idata;
    if (issue) ram_q <= mem[{rb, rcnt}];
  end

endmodule

// File: tb/tb_fft_bitrev_out.sv
// Scoreboard bench for fft_bitrev_out with N=16: reorder, backpressure, ping-pong, overflow, reset.
// Expected order follows FFT_BITREV_EN: bit-reversed data per natural bin when defined, identity otherwise.
module tb_fft_bitrev_out;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          iclk;
  logic          rst_n;
  logic          ien;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          oen;
  logic          ordy;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] odata;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  int brev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [AW+DW-1:0] sb [$];
  bit               prev_stall = 0;
  logic [AW-1:0]    prev_addr;
  logic [DW-1:0]    prev_data;

  fft_bitrev_out #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iclk(iclk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .idata(idata),
    .oen(oen), .ordy(ordy), .oaddr(oaddr), .odata(odata), .ovf(ovf)
  );

  initial begin
    iclk = 0;
    forever #5 iclk = ~iclk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int exp_data(int off, int k);
`ifdef FFT_BITREV_EN
    return off + brev[k];
`else
    return off + k;
`endif
  endfunction

  // Sends one frame with iaddr=0..15 and idata=off+iaddr, optionally queueing its expected output.
  task automatic apply_frame(input int off, input bit push);
    if (push)
      for (int k = 0; k < 16; k++) sb.push_back({AW'(k), DW'(exp_data(off, k))});
    for (int i = 0; i < 16; i++) begin
      ien   = 1'b1;
      iaddr = AW'(i);
      idata = DW'(off + i);
      @(posedge iclk);
      #1;
    end
    ien = 1'b0;
  endtask

  task automatic count_run(output int waited, output int run);
    waited = 0;
    run = 0;
    @(negedge iclk);
    while (!oen && waited < 100) begin
      waited++;
      @(negedge iclk);
    end
    while (oen && run < 100) begin
      run++;
      @(negedge iclk);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || oen) && n < 300) begin
      @(negedge iclk);
      n++;
    end
    check_output(name, 32'(sb.size() == 0 && !oen), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-stability across stalls.
  always @(negedge iclk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_output("hold_oen", 32'(oen), 32'd1);
        check_output("hold_oaddr", 32'(oaddr), 32'(prev_addr));
        check_output("hold_odata", 32'(odata), 32'(prev_data));
      end
      if (oen && ordy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got oaddr=%0d odata=%0d, expected no output", oaddr, odata);
        end else begin
          logic [AW+DW-1:0] e;
          e = sb.pop_front();
          check_output("oaddr", 32'(oaddr), 32'(e[AW+DW-1:DW]));
          check_output("odata", 32'(odata), 32'(e[DW-1:0]));
        end
      end
      prev_stall = oen && !ordy;
      prev_addr  = oaddr;
      prev_data  = odata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int run;
    bit found;
    rst_n = 0;
    ien   = 0;
    iaddr = '0;
    idata = '0;
    ordy  = 1;
    repeat (3) @(posedge iclk);
    #1;
    check_output("reset_oen", 32'(oen), 32'd0);
    check_output("reset_oaddr", 32'(oaddr), 32'd0);
    check_output("reset_odata", 32'(odata), 32'd0);
    check_output("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1;
    @(posedge iclk);
    #1;

    $display("[TB] reorder with latency");
    apply_frame(0, 1);
    count_run(waited, run);
    check_output("first_oen_latency", 32'(waited), 32'd2);
    check_output("frame_run_length", 32'(run), 32'd16);
    wait_drain("drain_reorder");

    $display("[TB] backpressure");
    fork
      apply_frame(0, 1);
      for (int c = 0; c < 70; c++) begin
        @(posedge iclk);
        #1;
        ordy = ~ordy;
      end
    join
    ordy = 1;
    wait_drain("drain_backpressure");

    $display("[TB] ping-pong");
    fork
      begin
        apply_frame(0, 1);
        apply_frame(100, 1);
      end
      count_run(waited, run);
    join
    check_output("pingpong_run_length", 32'(run), 32'd32);
    wait_drain("drain_pingpong");
    check_output("pingpong_ovf", 32'(ovf), 32'd0);

    $display("[TB] overflow");
    ordy = 0;
    apply_frame(200, 1);
    apply_frame(300, 1);
    check_output("ovf_before_third", 32'(ovf), 32'd0);
    apply_frame(400, 0);
    check_output("ovf_after_third", 32'(ovf), 32'd1);
    repeat (5) @(posedge iclk);
    #1;
    ordy = 1;
    wait_drain("drain_overflow");
    check_output("ovf_sticky", 32'(ovf), 32'd1);

    $display("[TB] reset mid-drain");
    apply_frame(0, 1);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge iclk);
      if (oen && oaddr == 4'd5) found = 1;
    end
    check_output("reached_word5", 32'(found), 32'd1);
    rst_n = 0;
    #1;
    sb.delete();
    check_output("reset_drops_oen", 32'(oen), 32'd0);
    check_output("reset_clears_ovf", 32'(ovf), 32'd0);
    @(posedge iclk);
    @(posedge iclk);
    #1;
    rst_n = 1;
    @(posedge iclk);
    #1;
    apply_frame(50, 1);
    wait_drain("drain_after_reset");

    repeat (5) @(posedge iclk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
